// File: rtl/lfsr_crypt_stream.sv
// Encryption stage: pads a message to a 64-byte frame of spaces, XORs each byte
// with a 7-bit LFSR stream and puts the parity of bits [6:0] into bit 7.
module lfsr_crypt_stream #(
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned MAX_MSG   = 49,
    parameter int unsigned PRE_MIN   = 10,
    parameter int unsigned PRE_MAX   = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] pre_len,
    input  logic [7:0] pt_sel,
    input  logic [6:0] seed,
    input  logic [5:0] msg_len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic [5:0] out_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       Busy,
    output logic       Done
);
    localparam int unsigned CNT_W = 7;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_MSG, S_POST, S_DONE} state_t;

    state_t             state, state_next;
    logic [3:0]         pre_q;
    logic [5:0]         msg_q;
    logic [6:0]         taps_q;
    logic [6:0]         lfsr;
    logic [CNT_W-1:0]   ld_cnt;
    logic               load;
    logic               slot_free;
    logic [6:0]         byte_src;
    logic [6:0]         enc_bits;
    logic [3:0]         pre_c;
    logic [5:0]         msg_c;
    logic [6:0]         seed_c;
    logic [6:0]         taps_c;
    logic [3:0]         tap_index;
    logic               unused_bits;

    assign unused_bits = ^{pt_sel[7:4], in_data[7]};

    // Configuration clamping and tap selection
    always_comb begin
        pre_c = pre_len[3:0];
        if (pre_len < 8'(PRE_MIN))      pre_c = 4'(PRE_MIN);
        else if (pre_len > 8'(PRE_MAX)) pre_c = 4'(PRE_MAX);
        msg_c     = (msg_len > 6'(MAX_MSG)) ? 6'(MAX_MSG) : msg_len;
        seed_c    = (seed == 7'd0) ? 7'd1 : seed;
        tap_index = (pt_sel[3:0] == 4'd8) ? 4'd8 : {1'b0, pt_sel[2:0]};
        case (tap_index)
            4'd0:    taps_c = 7'h60;
            4'd1:    taps_c = 7'h48;
            4'd2:    taps_c = 7'h78;
            4'd3:    taps_c = 7'h72;
            4'd4:    taps_c = 7'h6A;
            4'd5:    taps_c = 7'h69;
            4'd6:    taps_c = 7'h5C;
            4'd7:    taps_c = 7'h7E;
            default: taps_c = 7'h7B;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state, slot-load decision and input handshake
    always_comb begin
        state_next = state;
        load       = 1'b0;
        in_ready   = 1'b0;
        byte_src   = 7'h20;
        slot_free  = !out_valid || out_ready;
        case (state)
            S_IDLE: if (Start) state_next = S_PRE;
            S_PRE: begin
                load = slot_free;
                if (load && ld_cnt == CNT_W'(pre_q) - 7'd1)
                    state_next = (msg_q == 6'd0) ? S_POST : S_MSG;
            end
            S_MSG: begin
                in_ready = slot_free;
                byte_src = in_data[6:0];
                load     = in_valid && slot_free;
                if (load && ld_cnt == CNT_W'(pre_q) + CNT_W'(msg_q) - 7'd1)
                    state_next = S_POST;
            end
            S_POST: begin
                load = slot_free && (ld_cnt < CNT_W'(FRAME_LEN));
                if (ld_cnt == CNT_W'(FRAME_LEN) && out_valid && out_ready)
                    state_next = S_DONE;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign enc_bits = byte_src ^ lfsr;

    // Config latch, LFSR, output slot and status flags
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pre_q     <= 4'd0;
            msg_q     <= 6'd0;
            taps_q    <= 7'd0;
            lfsr      <= 7'd0;
            ld_cnt    <= '0;
            out_data  <= 8'd0;
            out_idx   <= 6'd0;
            out_valid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Busy <= (state_next != S_IDLE);
            Done <= (state_next == S_DONE);
            if (state == S_IDLE && Start) begin
                pre_q  <= pre_c;
                msg_q  <= msg_c;
                taps_q <= taps_c;
                lfsr   <= seed_c;
                ld_cnt <= '0;
            end else if (load) begin
                lfsr   <= {lfsr[5:0], ^(lfsr & taps_q)};
                ld_cnt <= ld_cnt + 7'd1;
            end
            if (load) begin
                out_data  <= {^enc_bits, enc_bits};
                out_idx   <= ld_cnt[5:0];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_crypt_stream.sv
// Directed bench for lfsr_crypt_stream: full-frame model checks, clamps,
// tap selection, backpressure and mid-run reset.
module tb_lfsr_crypt_stream;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] pre_len = 8'd0;
    logic [7:0] pt_sel = 8'd0;
    logic [6:0] seed = 7'd0;
    logic [5:0] msg_len = 6'd0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic [5:0] out_idx;
    logic       out_valid;
    logic       Busy;
    logic       Done;

    int total = 0;
    int bad = 0;
    logic [7:0] msg_mem [0:63];

    lfsr_crypt_stream dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .pre_len(pre_len),
        .pt_sel(pt_sel), .seed(seed), .msg_len(msg_len), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic [7:0] b, input logic [6:0] l);
        logic [6:0] x;
        x = b[6:0] ^ l;
        return {^x, x};
    endfunction

    task automatic fill_pattern();
        for (int i = 0; i < 64; i++) msg_mem[i] = 8'(i * 29 + 131);
    endtask

    task automatic fill_string(input string s);
        fill_pattern();
        for (int i = 0; i < s.len(); i++) msg_mem[i] = s[i];
    endtask

    // One complete run; ep/em/et/es are the hand-derived effective settings.
    task automatic run_frame(input string name, input logic [7:0] pl, input logic [7:0] ps,
                             input logic [6:0] sd, input logic [5:0] ml, input int ep,
                             input int em, input logic [6:0] et, input logic [6:0] es,
                             input bit bp, input bit kchk);
        logic [6:0] lf;
        logic [7:0] eb;
        logic [7:0] pd;
        logic [5:0] pi;
        logic [7:0] k7 [0:6];
        int exp_idx, consumed, cycles;
        bit stall;
        k7 = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00, 8'hE1};
        @(negedge Clk);
        pre_len = pl; pt_sel = ps; seed = sd; msg_len = ml;
        Start = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        check({name, ":busy_start"}, 32'(Busy), 32'd1);
        check({name, ":valid_start"}, 32'(out_valid), 32'd0);
        lf = es; exp_idx = 0; consumed = 0; cycles = 0; stall = 1'b0;
        pd = 8'd0; pi = 6'd0;
        while (exp_idx < 64 && cycles < 3000) begin
            if (stall) begin
                check({name, ":hold_valid"}, 32'(out_valid), 32'd1);
                check({name, ":hold_data"}, 32'(out_data), 32'(pd));
                check({name, ":hold_idx"}, 32'(out_idx), 32'(pi));
            end
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid  = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data   = msg_mem[consumed % 64];
            Start     = bp && (cycles == 30);
            #1;
            if (in_valid && in_ready) begin
                check({name, ":in_ready_window"}, 32'(consumed < em), 32'd1);
                consumed++;
            end
            if (out_valid && out_ready) begin
                eb = (exp_idx < ep || exp_idx >= ep + em) ? 8'h20 : msg_mem[exp_idx - ep];
                check({name, ":idx"}, 32'(out_idx), 32'(exp_idx));
                check({name, ":data"}, 32'(out_data), 32'(enc(eb, lf)));
                if (kchk && exp_idx < 7)
                    check({name, ":const_data"}, 32'(out_data), 32'(k7[exp_idx]));
                lf = {lf[5:0], ^(lf & et)};
                exp_idx++;
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            pi = out_idx;
            @(negedge Clk);
            cycles++;
        end
        Start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check({name, ":no_timeout"}, 32'(cycles < 3000), 32'd1);
        check({name, ":consumed"}, 32'(consumed), 32'(em));
        check({name, ":done_pulse"}, 32'(Done), 32'd1);
        check({name, ":busy_in_done"}, 32'(Busy), 32'd1);
        @(negedge Clk);
        check({name, ":done_low"}, 32'(Done), 32'd0);
        check({name, ":busy_low"}, 32'(Busy), 32'd0);
        check({name, ":valid_low"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int k, cyc;
        #1 Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst:out_valid", 32'(out_valid), 32'd0);
        check("rst:out_data", 32'(out_data), 32'd0);
        check("rst:out_idx", 32'(out_idx), 32'd0);
        check("rst:busy", 32'(Busy), 32'd0);
        check("rst:done", 32'(Done), 32'd0);
        check("rst:in_ready", 32'(in_ready), 32'd0);
        Reset = 1'b0;

        fill_pattern();
        run_frame("spaces60", 8'd12, 8'h00, 7'h01, 6'd0, 12, 0, 7'h60, 7'h01, 1'b0, 1'b1);

        fill_string("Mr. Watson, come here. I want to see you.");
        run_frame("watson", 8'd12, 8'h05, 7'h5A, 6'd41, 12, 41, 7'h69, 7'h5A, 1'b0, 1'b0);

        fill_pattern();
        run_frame("pre_lo", 8'd3, 8'h02, 7'h11, 6'd5, 10, 5, 7'h78, 7'h11, 1'b0, 1'b0);
        run_frame("pre_hi", 8'd200, 8'h07, 7'h2C, 6'd8, 15, 8, 7'h7E, 7'h2C, 1'b0, 1'b0);
        run_frame("seed0", 8'd11, 8'h08, 7'h00, 6'd3, 11, 3, 7'h7B, 7'h01, 1'b0, 1'b0);
        run_frame("msg_clip", 8'd15, 8'h0B, 7'h45, 6'd60, 15, 49, 7'h72, 7'h45, 1'b0, 1'b0);
        run_frame("tap_hi", 8'd10, 8'hF4, 7'h7F, 6'd20, 10, 20, 7'h6A, 7'h7F, 1'b0, 1'b0);

        fill_string("Mr. Watson, come here. I want to see you.");
        run_frame("backpress", 8'd12, 8'h1E, 7'h33, 6'd41, 12, 41, 7'h5C, 7'h33, 1'b1, 1'b0);

        // Abort a run in the middle of the message
        @(negedge Clk);
        pre_len = 8'd12; pt_sel = 8'h00; seed = 7'h01; msg_len = 6'd41;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; k = 0; cyc = 0;
        while (!(out_valid && out_idx == 6'd20) && cyc < 200) begin
            out_ready = 1'b1; in_valid = 1'b1; in_data = msg_mem[k % 64];
            #1;
            if (in_valid && in_ready) k++;
            @(negedge Clk);
            cyc++;
        end
        check("midrst:reached_idx20", 32'(cyc < 200), 32'd1);
        Reset = 1'b1;
        #1;
        check("midrst:out_valid", 32'(out_valid), 32'd0);
        check("midrst:busy", 32'(Busy), 32'd0);
        check("midrst:in_ready", 32'(in_ready), 32'd0);
        check("midrst:out_idx", 32'(out_idx), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("midrst:quiet", 32'(out_valid), 32'd0);
        check("midrst:idle_busy", 32'(Busy), 32'd0);
        run_frame("after_rst", 8'd12, 8'h00, 7'h01, 6'd41, 12, 41, 7'h60, 7'h01, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lfsr_crypt_stream.md
Name: lfsr_crypt_stream

Overview:
Hardware encryption stage that sits between the data-memory message reader (upstream) and the data-memory result writer (downstream) in TopLevel.
- Pads a raw ASCII message with leading and trailing spaces to exactly 64 bytes.
- XORs each byte with a 7-bit maximal-length LFSR sequence and replaces bit 7 with the parity of bits [6:0].
- Output bytes carry an index so the writer can store byte i at DM address 64+i.

Parameters:
- FRAME_LEN, 64, total output bytes per run.
- MAX_MSG, 49, message length clip.
- PRE_MIN, 10, lower clamp on preamble length.
- PRE_MAX, 15, upper clamp on preamble length.

Ports:
- Clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse in IDLE; latches configuration.
- pre_len  in  8  raw preamble length (DM[61]); clamped internally.
- pt_sel  in  8  raw tap-pattern select (DM[62]).
- seed  in  7  LFSR initial state (DM[63]).
- msg_len  in  6  raw message byte count.
- in_data  in  8  message byte from reader.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  8  encrypted byte with parity in bit 7.
- out_idx  out  6  frame position of out_data (0..63).
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  writer accepts this cycle.
- Busy  out  1  high from Start until Done.
- Done  out  1  one-cycle pulse after the last byte handshakes.

Behaviour:
- Reset (asynchronous, active-high) values: state=IDLE; in_ready=0; out_valid=0; out_data=0; out_idx=0; Busy=0; Done=0; LFSR=0. Reset mid-run aborts the run; no further output bytes are produced.
- Configuration latched on Start in IDLE; Start is ignored in any other state.
  - pre_len: <10 becomes 10; >15 becomes 15.
  - msg_len: >49 becomes 49.
  - seed: 0 becomes 1.
  - Tap select: if pt_sel[3:0]==8, index = 8; else index = pt_sel[2:0].
  - Tap table, index 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- States and transitions:
  - IDLE -> PRE on Start.
  - PRE: emits pre_len bytes of 0x20; -> MSG.
  - MSG: emits msg_len bytes taken from the input; -> POST. If msg_len==0, PRE goes directly to POST.
  - POST: emits 0x20 until idx==63 has handshaked; -> DONE.
  - DONE: Done=1 for exactly one cycle; Busy=0 from the next cycle; -> IDLE.
- Output slot is a single register. It loads when (!out_valid || out_ready) and a source byte is available.
  - PRE/POST: a space byte is always available.
  - MSG: available only when in_valid && in_ready.
- in_ready = (state==MSG) && (!out_valid || out_ready). Input is never accepted outside MSG.
- Encryption of byte b at frame index i with LFSR state L_i:
  - out_data[6:0] = b[6:0] ^ L_i.
  - out_data[7] = ^out_data[6:0]. Input bit 7 is discarded.
  - out_idx = i.
- LFSR sequence:
  - L_0 = seed.
  - L_{i+1} = {L_i[5:0], ^(L_i & taps)}.
  - Advances exactly once per byte loaded into the output slot, never on stall.
- Latency: 1 cycle from input accept (or space generation) to out_valid.
- Throughput: 1 byte/cycle when out_ready stays high; a full frame takes 64 cycles plus 1.
- Output hold rule: out_valid, once set, holds out_data/out_idx stable until out_ready is high.
- out_idx counts 0..63 with no wrap within a run; exactly 64 bytes are produced per run.
- Simultaneous handshake and reload in the same cycle is legal; the new byte is the next index.

Test Plan:
- Reset behaviour: assert Reset mid-MSG at idx 20 -> same cycle out_valid=0, Busy=0, in_ready=0. A following Start runs a full 64-byte frame from idx 0.
- Pattern 0x60 spaces: pt_sel=0, seed=0x01, pre_len=12, msg_len=0, out_ready=1 -> bytes 0..6 are 0x21, 0x22, 0x24, 0x28, 0x30, 0x00, 0xE1. Done pulses one cycle after idx 63.
- Configuration clamps:
  - pre_len=3 -> first message byte appears at idx 10.
  - pre_len=200 -> first message byte at idx 15.
  - seed=0 -> behaves as seed=1.
  - msg_len=60 -> exactly 49 bytes consumed.
- Tap select: pt_sel=0x08 -> taps 0x7B. pt_sel=0x0B -> taps 0x72 (index 3). Check against a bench model of the LFSR over all 64 bytes.
- Message run: "Mr. Watson, come here. I want to see you." (41 bytes), pre_len=12, random seed/pattern -> all 64 bytes match the bench model. in_ready is high only for idx 12..52.
- Backpressure: toggle out_ready randomly and in_valid with gaps -> out_data/out_idx stay stable while stalled, no index is skipped or duplicated, and the LFSR does not advance on stall cycles.
